// File: rtl/round_key_adder_pkg.sv
// Shared AES definitions: block-adder FSM encoding and default datapath sizes.
package round_key_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } rka_state_e;

    localparam int DEF_BLOCK_W  = 128;
    localparam int DEF_SLICE_W  = 32;
    localparam int DEF_NUM_KEYS = 11;

endpackage

// File: rtl/round_key_store.sv
// Round-key register file: one full-width write port, one slice-addressed read port.
module round_key_store
    import round_key_adder_pkg::*;
#(
    parameter int BLOCK_W  = DEF_BLOCK_W,
    parameter int SLICE_W  = DEF_SLICE_W,
    parameter int NUM_KEYS = DEF_NUM_KEYS
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         wr_en,
    input  logic [$clog2(NUM_KEYS)-1:0]                  wr_idx,
    input  logic [BLOCK_W-1:0]                           wr_data,
    input  logic [$clog2(NUM_KEYS)-1:0]                  rd_idx,
    input  logic [$clog2(BLOCK_W/SLICE_W)-1:0]           rd_slice,
    output logic [SLICE_W-1:0]                           rd_data
);

    localparam int IDX_W      = $clog2(NUM_KEYS);
    localparam int NUM_SLICES = BLOCK_W / SLICE_W;

    logic [BLOCK_W-1:0] entries [NUM_KEYS];
    logic [BLOCK_W-1:0] rd_entry;
    logic [SLICE_W-1:0] rd_slices [NUM_SLICES];

    // Each entry is its own register; an out-of-range write index matches no entry.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_entry
        logic [BLOCK_W-1:0] entry_q;
        logic [BLOCK_W-1:0] entry_d;

        always_comb begin
            entry_d = entry_q;
            if (wr_en && (wr_idx == IDX_W'(gi))) begin
                entry_d = wr_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign entries[gi] = entry_q;
    end

    always_comb begin
        rd_entry = '0;
        if ({1'b0, rd_idx} < (IDX_W+1)'(NUM_KEYS)) begin
            rd_entry = entries[rd_idx];
        end
    end

    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
        assign rd_slices[gi] = rd_entry[gi*SLICE_W +: SLICE_W];
    end

    assign rd_data = rd_slices[rd_slice];

endmodule

// File: rtl/round_key_adder.sv
// AES AddRoundKey engine: XORs a captured state block with a stored round key,
// one slice per cycle (MS slice first), behind valid/ready handshakes.
module round_key_adder
    import round_key_adder_pkg::*;
#(
    parameter int BLOCK_W  = DEF_BLOCK_W,
    parameter int SLICE_W  = DEF_SLICE_W,
    parameter int NUM_KEYS = DEF_NUM_KEYS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_we,
    input  logic [$clog2(NUM_KEYS)-1:0]   key_idx,
    input  logic [BLOCK_W-1:0]            key_data,
    output logic                          key_wr_ready,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BLOCK_W-1:0]            in_state,
    input  logic [$clog2(NUM_KEYS)-1:0]   in_round,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BLOCK_W-1:0]            out_state,
    output logic                          out_err
);

    localparam int IDX_W      = $clog2(NUM_KEYS);
    localparam int NUM_SLICES = BLOCK_W / SLICE_W;
    localparam int CNT_W      = $clog2(NUM_SLICES);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    rka_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BLOCK_W-1:0]  work_q, work_d;
    logic [IDX_W-1:0]    round_q, round_d;
    logic                err_q, err_d;

    logic [CNT_W-1:0]    slice_sel;
    logic [SLICE_W-1:0]  key_slice;
    logic [BLOCK_W-1:0]  xor_vec;
    logic                round_ok;

    assign round_ok  = {1'b0, round_q} < (IDX_W+1)'(NUM_KEYS);
    assign slice_sel = LAST_SLICE - cnt_q;

    round_key_store #(
        .BLOCK_W  (BLOCK_W),
        .SLICE_W  (SLICE_W),
        .NUM_KEYS (NUM_KEYS)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (key_we && key_wr_ready),
        .wr_idx   (key_idx),
        .wr_data  (key_data),
        .rd_idx   (round_q),
        .rd_slice (slice_sel),
        .rd_data  (key_slice)
    );

    // Key slice positioned over the slice being processed this cycle, zero elsewhere.
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_xor
        assign xor_vec[gi*SLICE_W +: SLICE_W] =
            (slice_sel == CNT_W'(gi)) ? key_slice : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        round_d = round_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_BUSY;
                    work_d  = in_state;
                    round_d = in_round;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_BUSY: begin
                if (round_ok) begin
                    work_d = work_q ^ xor_vec;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SLICE) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    err_d   = !round_ok;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            round_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            round_q <= round_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign key_wr_ready = (state_q != ST_BUSY);
    assign out_state    = work_q;
    assign out_err      = err_q;

endmodule

// File: tb/tb_round_key_adder.sv
// Randomised self-checking bench for round_key_adder against a key-table XOR reference model.
module tb_round_key_adder;

    localparam int BLOCK_W  = 128;
    localparam int SLICE_W  = 32;
    localparam int NUM_KEYS = 11;
    localparam int IDX_W    = 4;
    localparam int MAX_WAIT = 20;

    logic               clk;
    logic               rst_n;
    logic               key_we;
    logic [IDX_W-1:0]   key_idx;
    logic [BLOCK_W-1:0] key_data;
    logic               key_wr_ready;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_state;
    logic [IDX_W-1:0]   in_round;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_state;
    logic               out_err;

    logic [BLOCK_W-1:0] model_keys [NUM_KEYS];
    int vectors;
    int miscompares;

    round_key_adder #(
        .BLOCK_W  (BLOCK_W),
        .SLICE_W  (SLICE_W),
        .NUM_KEYS (NUM_KEYS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_we       (key_we),
        .key_idx      (key_idx),
        .key_data     (key_data),
        .key_wr_ready (key_wr_ready),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_state     (in_state),
        .in_round     (in_round),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_state    (out_state),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLOCK_W-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: AddRoundKey is a plain XOR with the selected key; bad round passes through with error.
    function automatic logic [BLOCK_W:0] ref_model(input logic [BLOCK_W-1:0] st, input logic [IDX_W-1:0] rnd);
        if (int'(rnd) < NUM_KEYS) return {1'b0, st ^ model_keys[rnd]};
        return {1'b1, st};
    endfunction

    task automatic write_key(input logic [IDX_W-1:0] idx, input logic [BLOCK_W-1:0] data);
        key_we   = 1'b1;
        key_idx  = idx;
        key_data = data;
        step();
        key_we = 1'b0;
        if (int'(idx) < NUM_KEYS) model_keys[idx] = data;
        $display("key write idx=%0d data=%h", idx, data);
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
            step();
            lat++;
        end
    endtask

    // Drives one block through the handshake and reports what was observed.
    task automatic run_block(input logic [BLOCK_W-1:0] st, input logic [IDX_W-1:0] rnd, input int hold,
                             output int lat, output logic [BLOCK_W-1:0] got, output logic got_err,
                             output logic rdy_seen);
        in_valid = 1'b1;
        in_state = st;
        in_round = rnd;
        rdy_seen = in_ready;
        step();
        in_valid = 1'b0;
        wait_out_valid(lat);
        got     = out_state;
        got_err = out_err;
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("block state=%h round=%0d -> out=%h err=%0d lat=%0d", st, rnd, got, got_err, lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({in_ready, out_valid, out_err, key_wr_ready} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 1001", {in_ready, out_valid, out_err, key_wr_ready});
        end
        vectors++;
        if (out_state !== '0) begin
            miscompares++;
            $display("FAIL reset_out_state: got %h expected 0", out_state);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_known_vector;
        logic [BLOCK_W-1:0] got;
        logic               err, rdy;
        int                 lat;
        write_key(4'd0, 128'ha0fafe1788542cb123a339392a6c7605);
        run_block(128'h046681e5e0cb199a48f8d37a2806264c, 4'd0, 0, lat, got, err, rdy);
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL kv_in_ready: got %b expected 1", rdy);
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL kv_latency: got %0d expected 4", lat);
        end
        vectors++;
        if (got !== 128'ha49c7ff2689f352b6b5bea43026a5049 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL kv_result: got %h err=%b expected a49c7ff2689f352b6b5bea43026a5049 err=0", got, err);
        end
        run_block(128'ha49c7ff2689f352b6b5bea43026a5049, 4'd0, 0, lat, got, err, rdy);
        vectors++;
        if (got !== 128'h046681e5e0cb199a48f8d37a2806264c || err !== 1'b0) begin
            miscompares++;
            $display("FAIL kv_feedback: got %h err=%b expected 046681e5e0cb199a48f8d37a2806264c err=0", got, err);
        end
    endtask

    task automatic test_bad_round;
        logic [BLOCK_W-1:0] st, got;
        logic               err, rdy;
        int                 lat;
        for (int r = NUM_KEYS; r < 16; r += 4) begin
            st = rand_block();
            run_block(st, IDX_W'(r), 0, lat, got, err, rdy);
            vectors++;
            if (got !== st || err !== 1'b1 || lat !== 4) begin
                miscompares++;
                $display("FAIL bad_round_%0d: got %h err=%b lat=%0d expected %h err=1 lat=4", r, got, err, lat, st);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [BLOCK_W-1:0] st;
        logic [BLOCK_W:0]   exp;
        int                 lat;
        st  = rand_block();
        exp = ref_model(st, 4'd0);
        in_valid = 1'b1;
        in_state = st;
        in_round = 4'd0;
        step();
        wait_out_valid(lat);
        vectors++;
        if (lat !== 4 || out_state !== exp[BLOCK_W-1:0]) begin
            miscompares++;
            $display("FAIL bp_first: got %h lat=%0d expected %h lat=4", out_state, lat, exp[BLOCK_W-1:0]);
        end
        // in_valid stays high: a stalled result must not let a new block in.
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== exp[BLOCK_W-1:0] || out_err !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got valid=%b ready=%b state=%h err=%b expected 1 0 %h 0",
                         i, out_valid, in_ready, out_state, out_err, exp[BLOCK_W-1:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        $display("block state=%h round=0 held 5 cycles -> out=%h", st, exp[BLOCK_W-1:0]);
    endtask

    task automatic test_busy_write;
        logic [BLOCK_W-1:0] st, got;
        logic [BLOCK_W:0]   exp;
        logic               err, rdy;
        int                 lat;
        st  = rand_block();
        exp = ref_model(st, 4'd0);
        in_valid = 1'b1;
        in_state = st;
        in_round = 4'd0;
        step();
        in_valid = 1'b0;
        vectors++;
        if (key_wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_wr_ready: got %b expected 0", key_wr_ready);
        end
        key_we   = 1'b1;
        key_idx  = 4'd0;
        key_data = '1;
        step();
        key_we = 1'b0;
        wait_out_valid(lat);
        vectors++;
        if (out_state !== exp[BLOCK_W-1:0] || lat !== 3) begin
            miscompares++;
            $display("FAIL busy_wr_current: got %h lat=%0d expected %h lat=3", out_state, lat, exp[BLOCK_W-1:0]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        st  = rand_block();
        exp = ref_model(st, 4'd0);
        run_block(st, 4'd0, 0, lat, got, err, rdy);
        vectors++;
        if (got !== exp[BLOCK_W-1:0] || err !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_wr_next: got %h expected %h", got, exp[BLOCK_W-1:0]);
        end
    endtask

    task automatic test_same_edge_write;
        logic [BLOCK_W-1:0] st, k;
        logic [IDX_W-1:0]   r;
        int                 lat;
        st = rand_block();
        k  = rand_block();
        r  = IDX_W'($urandom_range(0, NUM_KEYS - 1));
        key_we   = 1'b1;
        key_idx  = r;
        key_data = k;
        in_valid = 1'b1;
        in_state = st;
        in_round = r;
        step();
        key_we   = 1'b0;
        in_valid = 1'b0;
        model_keys[r] = k;
        wait_out_valid(lat);
        vectors++;
        if (out_state !== (st ^ k) || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge_write: got %h expected %h", out_state, st ^ k);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("block state=%h round=%0d with same-edge key %h", st, r, k);
    endtask

    task automatic test_random;
        logic [BLOCK_W-1:0] st, got;
        logic [BLOCK_W:0]   exp;
        logic [IDX_W-1:0]   r;
        logic               err, rdy;
        int                 lat;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) write_key(IDX_W'($urandom_range(0, 15)), rand_block());
            st  = rand_block();
            r   = IDX_W'($urandom_range(0, 13));
            exp = ref_model(st, r);
            run_block(st, r, int'($urandom_range(0, 3)), lat, got, err, rdy);
            vectors++;
            if (got !== exp[BLOCK_W-1:0] || err !== exp[BLOCK_W] || lat !== 4 || rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL random_%0d: got %h err=%b lat=%0d rdy=%b expected %h err=%b lat=4 rdy=1",
                         i, got, err, lat, rdy, exp[BLOCK_W-1:0], exp[BLOCK_W]);
            end
        end
    endtask

    task automatic test_reset_mid_busy;
        logic [BLOCK_W-1:0] st, got;
        logic               err, rdy, seen_valid;
        int                 lat;
        write_key(4'd0, rand_block());
        in_valid = 1'b1;
        in_state = rand_block();
        in_round = 4'd0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got valid=%b ready=%b state=%h expected 0 1 0", out_valid, in_ready, out_state);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_ready: got %b expected 1", in_ready);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) seen_valid = 1'b1;
            step();
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_no_valid: got out_valid pulse expected none");
        end
        for (int k = 0; k < NUM_KEYS; k++) model_keys[k] = '0;
        // Cleared key store makes every valid round an identity.
        for (int k = 0; k < NUM_KEYS; k++) begin
            st = rand_block();
            run_block(st, IDX_W'(k), 0, lat, got, err, rdy);
            vectors++;
            if (got !== st || err !== 1'b0) begin
                miscompares++;
                $display("FAIL cleared_key_%0d: got %h err=%b expected %h err=0", k, got, err, st);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        key_we      = 1'b0;
        key_idx     = '0;
        key_data    = '0;
        in_valid    = 1'b0;
        in_state    = '0;
        in_round    = '0;
        out_ready   = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) model_keys[k] = '0;

        test_reset();
        test_known_vector();
        test_bad_round();
        test_backpressure();
        test_busy_write();
        test_same_edge_write();
        test_random();
        test_reset_mid_busy();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/round_key_adder.md
ROUND_KEY_ADDER -- requirements
Module: round_key_adder

Interface
REQ-001 SHALL have parameter BLOCK_W, default 128, width of the state block and of each round key in bits.
REQ-002 SHALL have parameter SLICE_W, default 32, datapath width processed per cycle; BLOCK_W is an integer multiple of SLICE_W.
REQ-003 SHALL have parameter NUM_KEYS, default 11, number of round-key entries in the internal key store.
REQ-004 SHALL have port clk, input, 1, the single clock; all flops use its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports key_we (input, 1), key_idx (input, clog2(NUM_KEYS)) and key_data (input, BLOCK_W), the key-store write port.
REQ-007 SHALL have port key_wr_ready, output, 1, high when a key write is accepted this cycle.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_state (input, BLOCK_W) and in_round (input, clog2(NUM_KEYS)), the block input handshake.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_state (output, BLOCK_W) and out_err (output, 1), the result handshake.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 SHALL leave IDLE for BUSY when in_valid and in_ready are both high, capturing in_state and in_round.
REQ-012 SHALL assert in_ready only in IDLE.
REQ-013 SHALL in BUSY XOR one SLICE_W slice per cycle with the same slice of key store entry in_round, most-significant slice first, over BLOCK_W/SLICE_W cycles via a slice counter.
REQ-014 SHALL enter DONE on the cycle after the last slice, so out_valid rises exactly BLOCK_W/SLICE_W cycles after the accepting edge.
REQ-015 SHALL in DONE hold out_valid high and out_state/out_err stable until out_ready is high; on that edge it returns to IDLE.
REQ-016 SHALL with out_valid and out_ready both high in DONE return to IDLE; a new block is accepted no earlier than the following cycle.
REQ-017 SHALL when the captured in_round >= NUM_KEYS skip the XOR, pass the state unchanged and set out_err=1 in DONE; otherwise out_err=0.
REQ-018 SHALL assert key_wr_ready whenever state is not BUSY; a key_we with key_wr_ready low is dropped without effect.
REQ-019 SHALL ignore key writes with key_idx >= NUM_KEYS.
REQ-020 SHALL when a key write and a block accept occur on the same IDLE edge, make the processing of that block use the newly written key.
REQ-021 SHALL keep out_state equal to the working register, which is fully updated only in DONE; intermediate values are not exposed as valid.

Reset
REQ-022 SHALL on rst_n low asynchronously force state IDLE, slice counter 0, out_valid 0, out_err 0, out_state 0 and the working register 0.
REQ-023 SHALL on reset clear all key store entries to 0.
REQ-024 SHALL on reset asserted mid-BUSY or in DONE abandon the block with no out_valid pulse, with in_ready high on the first edge after release.

Structure
REQ-025 SHALL place the FSM state encoding and the default BLOCK_W, SLICE_W and NUM_KEYS constants in the shared aes package.
REQ-026 SHALL use one sub-module, round_key_store, holding the NUM_KEYS x BLOCK_W register array with one write port and one slice-addressed read port.

Verification
REQ-027 SHALL cover: write key 0 = a0fafe1788542cb123a339392a6c7605, process state 046681e5e0cb199a48f8d37a2806264c, round 0 -> out_state a49c7ff2689f352b6b5bea43026a5049, out_err 0, out_valid 4 cycles after accept.
REQ-028 SHALL cover: feed that result back with round 0 -> out_state 046681e5e0cb199a48f8d37a2806264c.
REQ-029 SHALL cover: in_round 11 with NUM_KEYS=11 -> out_state equals in_state, out_err 1.
REQ-030 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid and out_state stable, in_ready 0 throughout.
REQ-031 SHALL cover: key_we to index 0 during BUSY with data all-ones -> key_wr_ready 0, current and next results use the old key.
REQ-032 SHALL cover: rst_n pulsed low on slice 2 -> no out_valid, in_ready 1 after release, key store reads 0.
